tick_led_sequencer: RTL
=======================

TICK_LED_SEQUENCER -- requirements
Module: tick_led_sequencer

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of flip-flops in the in_wave synchronizer, minimum 2.
REQ-002 Port clk, input, 1: single system clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1: reset, asynchronous and active-high.
REQ-004 Port in_wave, input, 1: slow square wave from the clock-divider stage, asynchronous to clk.
REQ-005 Port mode, input, 2: pattern select; 00 rotate, 01 bounce, 10 binary count, 11 bar fill/drain.
REQ-006 Port run, input, 1: 1 applies steps, 0 pauses.
REQ-007 Port led, output, 8: registered LED pattern.
REQ-008 Port step_pulse, output, 1: registered, high for one clk cycle per applied step.
REQ-009 Port wrap, output, 1: registered, high for one clk cycle when a pattern completes a cycle.

Function
REQ-010 in_wave SHALL pass through SYNC_STAGES flip-flops; a rising edge of the synchronized signal (previous 0, current 1) SHALL form one step request.
REQ-011 With SYNC_STAGES=2, in_wave first sampled high at clk edge k SHALL update led, step_pulse and wrap at edge k+2; falling edges SHALL produce nothing.
REQ-012 A step request SHALL be applied only when run=1; with run=0 it SHALL be discarded, and led, state and the stored mode SHALL hold.
REQ-013 States SHALL be ROT, SCAN_L, SCAN_R, COUNT, FILL and DRAIN; a stored mode register mode_q SHALL record the mode being executed.
REQ-014 On an applied step with mode != mode_q: mode_q <= mode, and the initial load SHALL be used (00: ROT, led 0x01; 01: SCAN_L, 0x01; 10: COUNT, 0x00; 11: FILL, 0x00); step_pulse=1, wrap=0, no shift.
REQ-015 Mode changes SHALL take effect only on an applied step; between steps led SHALL hold.
REQ-016 ROT: led <= {led[6:0], led[7]}; wrap=1 on the step from 0x80 to 0x01.
REQ-017 SCAN_L: led <= led<<1; reaching 0x80 SHALL move to SCAN_R; wrap=0.
REQ-018 SCAN_R: led <= led>>1; reaching 0x01 SHALL move to SCAN_L with wrap=1.
REQ-019 COUNT: led <= led+1, mod 256; wrap=1 on the step from 0xFF to 0x00.
REQ-020 FILL: led <= {led[6:0],1'b1}; reaching 0xFF SHALL move to DRAIN; wrap=0.
REQ-021 DRAIN: led <= led>>1; reaching 0x00 SHALL move to FILL with wrap=1.
REQ-022 Each applied step SHALL assert step_pulse for exactly one cycle, including mode-change loads.
REQ-023 When no step is applied, step_pulse and wrap SHALL be 0.
REQ-024 Back-to-back synchronized edges SHALL each be applied; no request SHALL be queued across a pause.
REQ-025 A step arriving in the cycle run rises SHALL be applied; a step in the cycle run falls (run=0 sampled) SHALL be discarded.

Reset
REQ-026 While rst=1, regardless of clk: synchronizer and edge flops 0, state ROT, mode_q 00, led 0x01, step_pulse 0, wrap 0.
REQ-027 in_wave high at reset release SHALL NOT create a step; only a subsequent 0->1 transition SHALL create one.
REQ-028 Reset asserted mid-pattern SHALL abandon the pattern immediately; the first step after release, with mode 00, SHALL produce 0x02.

Verification
REQ-029 mode=00, run=1, 8 in_wave pulses -> led 0x02,0x04,...,0x80,0x01; wrap only on the 8th; step_pulse on each, 2 clocks after the sampled edge.
REQ-030 mode=01, 15 pulses -> led walks 0x01 to 0x80 and back to 0x01; wrap exactly once, on the 15th; turnaround at 0x80 has no repeated value.
REQ-031 mode=10 from 0x00, 256 pulses -> led 0x00 after the last, wrap only on step 256; then mode=11, 1 pulse -> led 0x00, FILL, wrap 0; 8 more pulses -> 0xFF.
REQ-032 run=0 while 5 pulses arrive -> led, state, step_pulse unchanged; run=1 -> the next pulse continues from the held pattern.
REQ-033 rst pulsed asynchronously between clk edges while in SCAN_R at 0x10 -> led 0x01, outputs 0 immediately; in_wave held high through release -> no step until the next 0->1.

Source files
------------

// File: rtl/tick_led_sequencer.sv
// LED pattern sequencer stepped by rising edges of a slow, asynchronous square wave.
// Four patterns are available: rotate, bounce, binary count and bar fill/drain.
module tick_led_sequencer #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_wave,
   input  logic [1:0] mode,
   input  logic       run,
   output logic [7:0] led,
   output logic       step_pulse,
   output logic       wrap
);

   typedef enum logic [2:0] {
      ROT    = 3'd0,
      SCAN_L = 3'd1,
      SCAN_R = 3'd2,
      COUNT  = 3'd3,
      FILL   = 3'd4,
      DRAIN  = 3'd5
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] vld_q;
   logic                   prev_q;
   logic                   armed_q;
   logic                   syncLast;
   logic                   rise;
   logic                   apply;

   state_t     state_q, state_d;
   logic [1:0] mode_q, mode_d;
   logic [7:0] led_q, led_d;
   logic       step_q, step_d;
   logic       wrap_q, wrap_d;

   assign syncLast = sync_q[SYNC_STAGES-1];
   assign rise     = syncLast & ~prev_q & armed_q;
   assign apply    = rise & run;

   // Edges are only accepted once the synchronizer has carried a genuine low
   // sample, so a wave already high at reset release cannot fake a step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= '0;
         vld_q   <= '0;
         prev_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], in_wave};
         vld_q   <= {vld_q[SYNC_STAGES-2:0], 1'b1};
         prev_q  <= syncLast;
         armed_q <= armed_q | (vld_q[SYNC_STAGES-1] & ~syncLast);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ROT;
         mode_q  <= 2'b00;
         led_q   <= 8'h01;
         step_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         led_q   <= led_d;
         step_q  <= step_d;
         wrap_q  <= wrap_d;
      end
   end

   // A mode change only loads the new pattern's start value; shifting resumes
   // on the following step.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      led_d   = led_q;
      step_d  = 1'b0;
      wrap_d  = 1'b0;
      if (apply) begin
         step_d = 1'b1;
         if (mode != mode_q) begin
            mode_d = mode;
            case (mode)
               2'b00:   begin state_d = ROT;    led_d = 8'h01; end
               2'b01:   begin state_d = SCAN_L; led_d = 8'h01; end
               2'b10:   begin state_d = COUNT;  led_d = 8'h00; end
               default: begin state_d = FILL;   led_d = 8'h00; end
            endcase
         end else begin
            case (state_q)
               ROT: begin
                  led_d  = {led_q[6:0], led_q[7]};
                  wrap_d = (led_q == 8'h80);
               end
               SCAN_L: begin
                  led_d = led_q << 1;
                  if (led_d == 8'h80) state_d = SCAN_R;
               end
               SCAN_R: begin
                  led_d = led_q >> 1;
                  if (led_d == 8'h01) begin
                     state_d = SCAN_L;
                     wrap_d  = 1'b1;
                  end
               end
               COUNT: begin
                  led_d  = led_q + 8'd1;
                  wrap_d = (led_q == 8'hFF);
               end
               FILL: begin
                  led_d = {led_q[6:0], 1'b1};
                  if (led_d == 8'hFF) state_d = DRAIN;
               end
               DRAIN: begin
                  led_d = led_q >> 1;
                  if (led_d == 8'h00) begin
                     state_d = FILL;
                     wrap_d  = 1'b1;
                  end
               end
               default: begin
                  state_d = ROT;
                  led_d   = 8'h01;
               end
            endcase
         end
      end
   end

   always_comb begin
      led        = led_q;
      step_pulse = step_q;
      wrap       = wrap_q;
   end

endmodule
